// File: rtl/prog_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_loader_if
// Purpose  : Byte-stream load channel (valid/ready) feeding prog_mem_loader.
// Revision : 1.0  initial release
// ============================================================================
interface prog_mem_loader_if;
    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_last;
    logic       ld_ready;

    modport master (output ld_valid, output ld_byte, output ld_last, input ld_ready);
    modport slave  (input ld_valid, input ld_byte, input ld_last, output ld_ready);
endinterface
`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_loader
// Purpose  : Program/data memory for mproc. Loads a byte stream, packs byte
//            pairs (high byte first) into 16-bit words at sequential
//            addresses, holds the core in reset while loading and releases
//            it HOLD_CYC+1 edges after the last byte is accepted.
// Revision : 1.0  initial release
// ============================================================================
module prog_mem_loader #(
    parameter int AW       = 7,
    parameter int DW       = 16,
    parameter int HOLD_CYC = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    prog_mem_loader_if.slave   ld,
    input  wire logic          ld_restart,
    input  wire logic [AW-1:0] cpu_addr,
    output logic [DW-1:0]      cpu_din,
    output logic               cpu_reset,
    output logic [AW:0]        words,
    output logic               ovf
);

    localparam int          DEPTH_INT = 1 << AW;
    localparam logic [AW:0] DEPTH     = (AW+1)'(DEPTH_INT);
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYC);

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        HOLD    = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t         state, state_next;
    logic [3:0]     hold_cnt, hold_cnt_next;
    logic [7:0]     hi_reg;
    logic [AW:0]    wptr;
    logic           ovf_r;
    logic           cpu_reset_r;
    logic           ready;
    logic           wr_en;
    logic [DW-1:0]  wr_data;
    logic           full;
    logic [DW-1:0]  mem [0:DEPTH_INT-1];

    // Ready is decoded purely from the registered state.
    assign ready       = (state == LOAD_HI) || (state == LOAD_LO);
    assign ld.ld_ready = ready;
    assign full        = (wptr == DEPTH);

    // Next-state, hold counter and write request decode.
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        wr_en         = 1'b0;
        wr_data       = '0;
        case (state)
            LOAD_HI: begin
                if (ld.ld_valid) begin
                    if (ld.ld_last) begin
                        wr_en         = 1'b1;
                        wr_data       = {ld.ld_byte, 8'h00};
                        state_next    = HOLD;
                        hold_cnt_next = 4'd0;
                    end else begin
                        state_next = LOAD_LO;
                    end
                end
            end
            LOAD_LO: begin
                if (ld.ld_valid) begin
                    wr_en   = 1'b1;
                    wr_data = {hi_reg, ld.ld_byte};
                    if (ld.ld_last) begin
                        state_next    = HOLD;
                        hold_cnt_next = 4'd0;
                    end else begin
                        state_next = LOAD_HI;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt + 4'd1;
                end
            end
            RUN: begin
                if (ld_restart) begin
                    state_next = LOAD_HI;
                end
            end
            default: state_next = LOAD_HI;
        endcase
    end

    // State, hold counter and registered core reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LOAD_HI;
            hold_cnt    <= 4'd0;
            cpu_reset_r <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            cpu_reset_r <= (state_next == RUN);
        end
    end

    // High byte holding register for the word being assembled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg <= 8'h00;
        end else if ((state == LOAD_HI) && ld.ld_valid && !ld.ld_last) begin
            hi_reg <= ld.ld_byte;
        end
    end

    // Write pointer (doubles as the word count) and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            ovf_r <= 1'b0;
        end else if ((state == RUN) && ld_restart) begin
            wptr  <= '0;
            ovf_r <= 1'b0;
        end else if (wr_en) begin
            if (full) begin
                ovf_r <= 1'b1;
            end else begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    // Memory array: cleared by reset, written at the pointer unless full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_INT; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !full) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    assign cpu_din   = mem[cpu_addr];
    assign cpu_reset = cpu_reset_r;
    assign words     = wptr;
    assign ovf       = ovf_r;

endmodule
`default_nettype wire
